// File: rtl/eth_rx_framer.sv
// Ethernet receive framer: locks onto preamble + SFD, strips them and streams the
// frame payload (DA..FCS) as registered chunks with sof/eof/err/byte-count sidebands.
module eth_rx_framer #(
    parameter int N            = 4,
    parameter int MIN_PRE_BITS = 32,
    parameter int MAX_BYTES    = 1522
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] eth_rxd,
    input  logic         eth_crsdv,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic         sof,
    output logic         eof,
    output logic         err,
    output logic [10:0]  frame_bytes
);
    localparam logic [7:0]   PRE_BYTE   = 8'h55;
    localparam logic [7:0]   SFD_BYTE   = 8'hD5;
    localparam logic [N-1:0] P          = PRE_BYTE[N-1:0];
    localparam logic [N-1:0] S          = SFD_BYTE[7:8-N];
    localparam int           MIN_CNT    = MIN_PRE_BITS / N;
    localparam int           CPB        = 8 / N;
    localparam logic [1:0]   LAST_CHUNK = 2'(CPB - 1);
    localparam logic [10:0]  MAX_B      = 11'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, PRE, PAYLOAD, DROP, DROP_ERR} state_t;

    state_t      state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]  chunk_q, chunk_d;
    logic [10:0] byte_q, byte_d;
    logic        first_q, first_d;
    logic        over_q, over_d;
    logic        axiov_q, axiov_d;
    logic [N-1:0] axiod_q, axiod_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        err_q, err_d;
    logic [10:0] fb_q, fb_d;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        chunk_d   = chunk_q;
        byte_d    = byte_q;
        first_d   = first_q;
        over_d    = over_q;
        axiov_d   = 1'b0;
        axiod_d   = '0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        err_d     = 1'b0;
        fb_d      = '0;
        case (state_q)
            IDLE: begin
                if (eth_crsdv) begin
                    if (eth_rxd == P) begin
                        state_d   = PRE;
                        pre_cnt_d = 6'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PRE: begin
                if (!eth_crsdv) begin
                    state_d = IDLE;
                end else if (eth_rxd == P) begin
                    if (pre_cnt_q != 6'd63) pre_cnt_d = pre_cnt_q + 6'd1;
                end else if (eth_rxd == S && int'(pre_cnt_q) >= MIN_CNT) begin
                    state_d = PAYLOAD;
                    chunk_d = '0;
                    byte_d  = '0;
                    first_d = 1'b1;
                    over_d  = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
            PAYLOAD: begin
                if (!eth_crsdv) begin
                    eof_d   = 1'b1;
                    fb_d    = byte_q;
                    err_d   = (chunk_q != 2'd0);
                    state_d = IDLE;
                end else if (byte_q >= MAX_B) begin
                    // Full frame budget already delivered; swallow the rest.
                    over_d  = 1'b1;
                    state_d = DROP_ERR;
                end else begin
                    axiov_d = 1'b1;
                    axiod_d = eth_rxd;
                    sof_d   = first_q;
                    first_d = 1'b0;
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_d = '0;
                        byte_d  = byte_q + 11'd1;
                    end else begin
                        chunk_d = chunk_q + 2'd1;
                    end
                end
            end
            DROP_ERR: begin
                if (!eth_crsdv) begin
                    eof_d   = 1'b1;
                    err_d   = over_q;
                    fb_d    = MAX_B;
                    over_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (!eth_crsdv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            chunk_q   <= '0;
            byte_q    <= '0;
            first_q   <= 1'b0;
            over_q    <= 1'b0;
            axiov_q   <= 1'b0;
            axiod_q   <= '0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
            fb_q      <= '0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            chunk_q   <= chunk_d;
            byte_q    <= byte_d;
            first_q   <= first_d;
            over_q    <= over_d;
            axiov_q   <= axiov_d;
            axiod_q   <= axiod_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            err_q     <= err_d;
            fb_q      <= fb_d;
        end
    end

    assign axiov       = axiov_q;
    assign axiod       = axiod_q;
    assign sof         = sof_q;
    assign eof         = eof_q;
    assign err         = err_q;
    assign frame_bytes = fb_q;
endmodule

// File: tb/tb_eth_rx_framer.sv
// Frame-level bench: builds randomized frame streams, derives expected per-cycle
// outputs from frame descriptions, and compares three framer instances cycle by cycle.
module tb_eth_rx_framer;
    localparam int MAXA  = 1522;
    localparam int MAXB  = 4;
    localparam int DEPTH = 8192;

    typedef struct packed {
        logic        v;
        logic [3:0]  d;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] fb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, crsdv4 = 1'b0;
    logic [3:0] rxd4 = '0;
    logic       rst2 = 1'b1, crsdv2 = 1'b0;
    logic [1:0] rxd2 = '0;

    logic a_v, a_sof, a_eof, a_err; logic [3:0] a_d; logic [10:0] a_fb;
    logic b_v, b_sof, b_eof, b_err; logic [3:0] b_d; logic [10:0] b_fb;
    logic c_v, c_sof, c_eof, c_err; logic [1:0] c_d; logic [10:0] c_fb;

    eth_rx_framer #(.N(4), .MIN_PRE_BITS(32), .MAX_BYTES(MAXA)) dut_a (
        .clk(clk), .rst(rst4), .eth_rxd(rxd4), .eth_crsdv(crsdv4),
        .axiov(a_v), .axiod(a_d), .sof(a_sof), .eof(a_eof), .err(a_err), .frame_bytes(a_fb));
    eth_rx_framer #(.N(4), .MIN_PRE_BITS(32), .MAX_BYTES(MAXB)) dut_b (
        .clk(clk), .rst(rst4), .eth_rxd(rxd4), .eth_crsdv(crsdv4),
        .axiov(b_v), .axiod(b_d), .sof(b_sof), .eof(b_eof), .err(b_err), .frame_bytes(b_fb));
    eth_rx_framer #(.N(2), .MIN_PRE_BITS(32), .MAX_BYTES(MAXA)) dut_c (
        .clk(clk), .rst(rst2), .eth_rxd(rxd2), .eth_crsdv(crsdv2),
        .axiov(c_v), .axiod(c_d), .sof(c_sof), .eof(c_eof), .err(c_err), .frame_bytes(c_fb));

    bit   s4_r[DEPTH], s4_v[DEPTH]; int s4_d[DEPTH];
    bit   s2_r[DEPTH], s2_v[DEPTH]; int s2_d[DEPTH];
    exp_t ea[DEPTH], eb[DEPTH], ec[DEPTH];
    int   len4 = 0, len2 = 0;
    int   pl[$];
    int   nerr = 0, nchk = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int n, input bit r, input bit v, input int d);
        if (n == 4) begin
            s4_r[len4] = r; s4_v[len4] = v; s4_d[len4] = d;
            ea[len4] = '0; eb[len4] = '0; len4++;
        end else begin
            s2_r[len2] = r; s2_v[len2] = v; s2_d[len2] = d;
            ec[len2] = '0; len2++;
        end
    endtask

    task automatic set_exp(input int sel, input int idx, input exp_t e);
        case (sel)
            0:       ea[idx] = e;
            1:       eb[idx] = e;
            default: ec[idx] = e;
        endcase
    endtask

    // Expected outputs of an accepted frame: payload capped at maxb bytes, eof after drop.
    task automatic model(input int sel, input int n, input int maxb, input int pidx,
                         input int eidx, input bit has_eof);
        int cpb, lim, k;
        exp_t e;
        cpb = 8 / n;
        lim = maxb * cpb;
        k   = pl.size();
        for (int c = 0; c < k && c < lim; c++) begin
            e = '0; e.v = 1'b1; e.d = 4'(pl[c]); e.sof = (c == 0);
            set_exp(sel, pidx + c, e);
        end
        if (has_eof) begin
            e = '0; e.eof = 1'b1;
            if (k <= lim) begin
                e.fb = 11'(k / cpb); e.err = (k % cpb) != 0;
            end else begin
                e.fb = 11'(maxb); e.err = 1'b1;
            end
            set_exp(sel, eidx, e);
        end
    endtask

    // kind: 1 = SFD follows preamble, 0 = bad delimiter, 2 = carrier drops in preamble.
    // rst_extra > 0: reset pulse after the payload, then rst_extra stray chunks.
    task automatic frame(input int n, input int pre, input int kind, input int gap,
                         input int rst_extra);
        int p, s, mincnt, pidx, eidx, bad, lenb;
        bit acc;
        p = (n == 4) ? 5 : 1;
        s = (n == 4) ? 13 : 3;
        mincnt = 32 / n;
        for (int i = 0; i < pre; i++) push(n, 0, 1, p);
        if (kind == 1) push(n, 0, 1, s);
        else if (kind == 0) begin
            do bad = $urandom_range(0, (1 << n) - 1); while (bad == p || bad == s);
            push(n, 0, 1, bad);
        end
        pidx = (n == 4) ? len4 : len2;
        if (kind != 2) begin
            foreach (pl[c]) push(n, 0, 1, pl[c]);
            if (rst_extra > 0) begin
                push(n, 1, 1, $urandom_range(0, (1 << n) - 1));
                for (int i = 0; i < rst_extra; i++) begin
                    do bad = $urandom_range(0, (1 << n) - 1); while (bad == p);
                    push(n, 0, 1, bad);
                end
            end
        end
        eidx = (n == 4) ? len4 : len2;
        for (int i = 0; i < gap; i++) push(n, 0, 0, $urandom_range(0, (1 << n) - 1));
        lenb = (pre > 63) ? 63 : pre;
        acc = (kind == 1) && (pre >= 1) && (lenb >= mincnt);
        if (acc) begin
            if (n == 4) begin
                model(0, 4, MAXA, pidx, eidx, rst_extra == 0);
                model(1, 4, MAXB, pidx, eidx, rst_extra == 0);
            end else begin
                model(2, 2, MAXA, pidx, eidx, rst_extra == 0);
            end
        end
    endtask

    task automatic rand_pl(input int n, input int k);
        pl.delete();
        for (int c = 0; c < k; c++) pl.push_back($urandom_range(0, (1 << n) - 1));
    endtask

    task automatic rand_frame(input int n);
        int r, pre, kind, mincnt;
        mincnt = 32 / n;
        r = $urandom_range(0, 9);
        if (r == 0)      pre = $urandom_range(0, mincnt - 1);
        else if (r == 1) pre = $urandom_range(60, 70);
        else             pre = $urandom_range(mincnt, mincnt + 12);
        r = $urandom_range(0, 9);
        kind = (r == 0) ? 0 : (r == 1) ? 2 : 1;
        rand_pl(n, $urandom_range(0, 20));
        frame(n, pre, kind, $urandom_range(1, 3), 0);
    endtask

    task automatic cmp(input string who, input exp_t e, input logic v, input logic [3:0] d,
                       input logic so, input logic eo, input logic er, input logic [10:0] fb);
        chk({who, ".axiov"}, 32'(v), 32'(e.v));
        chk({who, ".axiod"}, 32'(d), 32'(e.d));
        chk({who, ".sof"}, 32'(so), 32'(e.sof));
        chk({who, ".eof"}, 32'(eo), 32'(e.eof));
        if (e.eof) begin
            chk({who, ".err"}, 32'(er), 32'(e.err));
            chk({who, ".frame_bytes"}, 32'(fb), 32'(e.fb));
        end
    endtask

    initial begin
        push(4, 1, 0, 0); push(4, 1, 1, 5);
        push(2, 1, 0, 0); push(2, 1, 1, 1);

        pl = '{4'hF, 4'hF, 4'h2, 4'h1, 4'h4, 4'h3};
        frame(4, 15, 1, 2, 0);
        rand_pl(4, 4);  frame(4, 7, 1, 2, 0);    // short preamble
        rand_pl(4, 5);  frame(4, 15, 1, 2, 0);   // odd nibble count
        rand_pl(4, 12); frame(4, 15, 1, 2, 0);   // oversize on the MAXB instance
        rand_pl(4, 8);  frame(4, 15, 1, 1, 0);   // exactly MAXB bytes, back-to-back
        pl.delete();    frame(4, 8, 1, 1, 0);    // zero payload, minimum preamble
        rand_pl(4, 6);  frame(4, 70, 1, 1, 0);   // saturating preamble count
        rand_pl(4, 3);  frame(4, 15, 1, 2, 4);   // reset mid-payload
        rand_pl(4, 4);  frame(4, 15, 1, 2, 0);   // recovery frame
        for (int i = 0; i < 40; i++) rand_frame(4);

        pl = '{2'b01, 2'b01, 2'b10, 2'b10};
        frame(2, 31, 1, 1, 0);
        rand_pl(2, 8);  frame(2, 31, 1, 2, 0);
        rand_pl(2, 3);  frame(2, 20, 1, 2, 0);
        rand_pl(2, 4);  frame(2, 15, 1, 2, 0);
        for (int i = 0; i < 25; i++) rand_frame(2);

        for (int i = 0; i < len4; i++) begin
            rst4 = s4_r[i]; crsdv4 = s4_v[i]; rxd4 = 4'(s4_d[i]);
            @(posedge clk); #1;
            cyc = i;
            cmp("n4", ea[i], a_v, a_d, a_sof, a_eof, a_err, a_fb);
            cmp("n4max4", eb[i], b_v, b_d, b_sof, b_eof, b_err, b_fb);
        end
        rst4 = 1'b1; crsdv4 = 1'b0;
        for (int i = 0; i < len2; i++) begin
            rst2 = s2_r[i]; crsdv2 = s2_v[i]; rxd2 = 2'(s2_d[i]);
            @(posedge clk); #1;
            cyc = i;
            cmp("n2", ec[i], c_v, {2'b00, c_d}, c_sof, c_eof, c_err, c_fb);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
